// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frames a DMA sample stream through an FFT core, counting samples per frame and frames per run.
// Optional build macro FFT_TLAST_CHECK_EN: flags o_err when s_axis_tlast disagrees with the input sample counter.
module fft_frame_ctrl #(
  parameter int DWIDTH  = 32,
  parameter int POINT_W = 11,
  parameter int BURST_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [POINT_W-1:0] i_point,
  input  logic [BURST_W-1:0] i_burst,
  input  logic [DWIDTH-1:0]  s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic               s_axis_tlast,
  output logic [DWIDTH-1:0]  c_in_tdata,
  output logic               c_in_tvalid,
  input  logic               c_in_tready,
  input  logic [DWIDTH-1:0]  c_out_tdata,
  input  logic               c_out_tvalid,
  output logic               c_out_tready,
  output logic [DWIDTH-1:0]  m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [POINT_W-1:0] POINT_ONE = {{(POINT_W-1){1'b0}}, 1'b1};
  localparam logic [POINT_W-1:0] POINT_MIN = POINT_W'(4);
  localparam logic [POINT_W-1:0] POINT_MAX = {1'b1, {(POINT_W-1){1'b0}}};
  localparam logic [BURST_W-1:0] BURST_ONE = {{(BURST_W-1){1'b0}}, 1'b1};

  logic [1:0]         state;
  logic [POINT_W-1:0] point_r;
  logic [BURST_W-1:0] burst_r;
  logic [POINT_W-1:0] in_cnt;
  logic [POINT_W-1:0] out_cnt;
  logic [BURST_W-1:0] in_frames;
  logic [BURST_W-1:0] out_frames;
  logic               start_d;

  logic               start_rise;
  logic               cfg_ok;
  logic               start_ok;
  logic [POINT_W-1:0] point_m1;
  logic [BURST_W-1:0] burst_m1;
  logic               in_en;
  logic               out_en;
  logic               in_hs;
  logic               out_hs;
  logic               in_wrap;
  logic               out_wrap;
  logic               in_final;
  logic               out_final;
  logic               tlast_err;

  assign start_rise = i_start & ~start_d;
  assign cfg_ok     = ((i_point & (i_point - POINT_ONE)) == '0) &&
                      (i_point >= POINT_MIN) && (i_point <= POINT_MAX) &&
                      (i_burst != '0);
  assign start_ok   = (state == IDLE) && start_rise && cfg_ok;

  assign point_m1 = point_r - POINT_ONE;
  assign burst_m1 = burst_r - BURST_ONE;

  assign in_en  = (state == RUN) && (in_frames < burst_r);
  assign out_en = ((state == RUN) || (state == DRAIN)) && (out_frames < burst_r);

  // Data never touches a register: the block only gates the handshakes around the core.
  assign c_in_tdata    = s_axis_tdata;
  assign c_in_tvalid   = s_axis_tvalid & in_en;
  assign s_axis_tready = c_in_tready & in_en;
  assign m_axis_tdata  = c_out_tdata;
  assign m_axis_tvalid = c_out_tvalid & out_en;
  assign c_out_tready  = m_axis_tready & out_en;
  assign m_axis_tlast  = out_en & (out_cnt == point_m1);
  assign o_busy        = (state != IDLE);

  assign in_hs     = s_axis_tvalid & s_axis_tready;
  assign out_hs    = m_axis_tvalid & m_axis_tready;
  assign in_wrap   = (in_cnt == point_m1);
  assign out_wrap  = (out_cnt == point_m1);
  assign in_final  = in_hs & in_wrap & (in_frames == burst_m1);
  assign out_final = out_hs & out_wrap & (out_frames == burst_m1);

`ifdef FFT_TLAST_CHECK_EN
  assign tlast_err = in_hs & (s_axis_tlast != in_wrap);
`else
  logic tlast_unused;
  assign tlast_unused = s_axis_tlast;
  assign tlast_err    = 1'b0;
`endif

  // Held at 1 through reset so an i_start already high does not look like a fresh edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_d <= 1'b1;
    end else begin
      start_d <= i_start;
    end
  end

  // Output completion wins over input completion so a same-cycle finish goes straight to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      point_r <= '0;
      burst_r <= '0;
      o_done  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            point_r <= i_point;
            burst_r <= i_burst;
            state   <= RUN;
          end
        end
        RUN: begin
          if (out_final) begin
            state  <= IDLE;
            o_done <= 1'b1;
          end else if (in_final) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_final) begin
            state  <= IDLE;
            o_done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      in_cnt     <= '0;
      out_cnt    <= '0;
      in_frames  <= '0;
      out_frames <= '0;
    end else begin
      if (in_hs) begin
        if (in_wrap) begin
          in_cnt    <= '0;
          in_frames <= in_frames + BURST_ONE;
        end else begin
          in_cnt <= in_cnt + POINT_ONE;
        end
      end
      if (out_hs) begin
        if (out_wrap) begin
          out_cnt    <= '0;
          out_frames <= out_frames + BURST_ONE;
        end else begin
          out_cnt <= out_cnt + POINT_ONE;
        end
      end
    end
  end

  // A start edge seen in IDLE re-grades the error flag; edges during a run are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_err <= 1'b0;
    end else if ((state == IDLE) && start_rise) begin
      o_err <= ~cfg_ok;
    end else if (tlast_err) begin
      o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: scoreboard bench; the bench plays DMA source, FFT core (FIFO or pass-through) and DMA sink.
// Expected o_err for the bad-tlast run follows FFT_TLAST_CHECK_EN.
module tb_fft_frame_ctrl;

  localparam int DW      = 32;
  localparam int POINT_W = 11;
  localparam int BURST_W = 10;
  localparam logic [DW-1:0] CORE_MASK = 32'hFFFF_0000;
  localparam int RUN_LIMIT = 3000;

`ifdef FFT_TLAST_CHECK_EN
  localparam bit TLAST_CHECK = 1'b1;
`else
  localparam bit TLAST_CHECK = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               i_start;
  logic [POINT_W-1:0] i_point;
  logic [BURST_W-1:0] i_burst;
  logic [DW-1:0]      s_axis_tdata;
  logic               s_axis_tvalid;
  logic               s_axis_tready;
  logic               s_axis_tlast;
  logic [DW-1:0]      c_in_tdata;
  logic               c_in_tvalid;
  logic               c_in_tready;
  logic [DW-1:0]      c_out_tdata;
  logic               c_out_tvalid;
  logic               c_out_tready;
  logic [DW-1:0]      m_axis_tdata;
  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic               m_axis_tlast;
  logic               o_busy;
  logic               o_done;
  logic               o_err;

  int checks = 0;
  int errors = 0;

  // Run model, shared between the driver tasks and the negedge monitor.
  int          run_point = 16;
  int          run_burst = 1;
  logic [15:0] run_tag   = 16'h0;
  int          in_acc    = 0;
  int          out_acc   = 0;
  int          done_cnt  = 0;
  bit          done_pend = 1'b0;
  bit          bypass    = 1'b0;
  logic [DW:0] exp_q[$];

  // Bench-side FFT core: a 4-deep FIFO that flips the upper half of each word.
  logic [DW-1:0] core_mem[0:7];
  logic [2:0]    core_wp = 3'd0;
  logic [2:0]    core_rp = 3'd0;
  logic [3:0]    core_cnt = 4'd0;
  bit            core_push = 1'b0;
  bit            core_pop = 1'b0;
  bit            core_flush = 1'b0;
  logic [DW-1:0] core_push_data = '0;

  assign c_in_tready  = bypass ? c_out_tready : (core_cnt < 4'd4);
  assign c_out_tvalid = bypass ? c_in_tvalid  : (core_cnt != 4'd0);
  assign c_out_tdata  = bypass ? c_in_tdata   : core_mem[core_rp];

  fft_frame_ctrl #(
    .DWIDTH (DW),
    .POINT_W(POINT_W),
    .BURST_W(BURST_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (i_start),
    .i_point      (i_point),
    .i_burst      (i_burst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .c_in_tdata   (c_in_tdata),
    .c_in_tvalid  (c_in_tvalid),
    .c_in_tready  (c_in_tready),
    .c_out_tdata  (c_out_tdata),
    .c_out_tvalid (c_out_tvalid),
    .c_out_tready (c_out_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (core_flush) begin
      core_wp  <= 3'd0;
      core_rp  <= 3'd0;
      core_cnt <= 4'd0;
    end else begin
      if (core_push) begin
        core_mem[core_wp] <= core_push_data;
        core_wp <= core_wp + 3'd1;
      end
      if (core_pop) core_rp <= core_rp + 3'd1;
      core_cnt <= core_cnt + 4'(core_push) - 4'(core_pop);
    end
  end

  // Handshakes are observed mid-cycle; they take effect at the following rising edge.
  always @(negedge clk) begin
    logic [DW:0]   exp_item;
    logic          exp_last;
    logic [DW-1:0] exp_data;
    if (done_pend || o_done) checkOutput("done_pulse", o_done, done_pend);
    done_pend = 1'b0;
    if (o_done) done_cnt++;
    core_push = 1'b0;
    core_pop  = 1'b0;
    if (c_in_tvalid && c_in_tready) begin
      checkOutput("c_in_data", c_in_tdata, s_axis_tdata);
      if (!bypass) begin
        core_push      = 1'b1;
        core_push_data = c_in_tdata ^ CORE_MASK;
      end
    end
    if (s_axis_tvalid && s_axis_tready) begin
      exp_last = ((in_acc % run_point) == run_point - 1);
      exp_data = bypass ? s_axis_tdata : (s_axis_tdata ^ CORE_MASK);
      exp_q.push_back({exp_last, exp_data});
      in_acc++;
    end
    if (!bypass && c_out_tvalid && c_out_tready) core_pop = 1'b1;
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        checkOutput("out_unexpected", 1, 0);
      end else begin
        exp_item = exp_q.pop_front();
        checkOutput("m_data", m_axis_tdata, exp_item[DW-1:0]);
        checkOutput("m_last", m_axis_tlast, exp_item[DW]);
      end
      out_acc++;
      if (out_acc == run_point * run_burst) done_pend = 1'b1;
    end
  end

  task automatic driveCycle(input bit rnd, input int bad);
    int total;
    total = run_point * run_burst;
    s_axis_tvalid = (in_acc < total) && (!rnd || ($urandom_range(1, 0) == 1));
    s_axis_tdata  = {run_tag, 16'(in_acc)};
    s_axis_tlast  = ((in_acc % run_point) == run_point - 1) || (in_acc == bad);
    m_axis_tready = !rnd || ($urandom_range(1, 0) == 1);
    @(posedge clk);
    #1;
  endtask

  task automatic startRun(input int pt, input int bu);
    core_flush = 1'b1;
    exp_q.delete();
    in_acc        = 0;
    out_acc       = 0;
    done_cnt      = 0;
    done_pend     = 1'b0;
    run_point     = (pt == 0) ? 1 : pt;
    run_burst     = bu;
    run_tag       = 16'($urandom);
    i_start       = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    @(posedge clk);
    #1;
    core_flush = 1'b0;
    i_point    = POINT_W'(pt);
    i_burst    = BURST_W'(bu);
    i_start    = 1'b1;
  endtask

  task automatic applyStimulus(input int pt, input int bu, input bit rnd, input int bad);
    int  cycles;
    logic exp_err;
    exp_err = (bad >= 0) && TLAST_CHECK;
    startRun(pt, bu);
    driveCycle(rnd, bad);
    checkOutput("busy_run", o_busy, 1);
    cycles = 0;
    while (done_cnt == 0 && cycles < RUN_LIMIT) begin
      driveCycle(rnd, bad);
      cycles++;
    end
    checkOutput("run_done", (done_cnt > 0) ? 1 : 0, 1);
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done_count", done_cnt, 1);
    checkOutput("out_count", out_acc, pt * bu);
    checkOutput("sb_empty", exp_q.size(), 0);
    checkOutput("busy_end", o_busy, 0);
    checkOutput("err_end", o_err, exp_err);
  endtask

  // Offers traffic on both sides and expects the block to keep every gate closed.
  task automatic idleCheck(input int n);
    for (int i = 0; i < n; i++) begin
      s_axis_tvalid = 1'b1;
      m_axis_tready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("idle_busy", o_busy, 0);
      checkOutput("idle_s_ready", s_axis_tready, 0);
      checkOutput("idle_c_out_ready", c_out_tready, 0);
      checkOutput("idle_c_in_valid", c_in_tvalid, 0);
      checkOutput("idle_m_valid", m_axis_tvalid, 0);
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
  endtask

  initial begin
    int waited;
    reset         = 1'b1;
    i_start       = 1'b1;
    i_point       = POINT_W'(16);
    i_burst       = BURST_W'(2);
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // i_start held high through reset must not launch a run.
    idleCheck(4);
    checkOutput("reset_err", o_err, 0);
    checkOutput("reset_done", o_done, 0);

    bypass = 1'b0;
    applyStimulus(16, 2, 1'b0, -1);
    applyStimulus(16, 2, 1'b1, -1);
    applyStimulus(16, 2, 1'b0, 7);

    // Pass-through core: last input and last output share one cycle.
    bypass = 1'b1;
    applyStimulus(8, 3, 1'b1, -1);
    applyStimulus(4, 1, 1'b0, -1);
    bypass = 1'b0;

    // Start still high after o_done: no new run.
    idleCheck(6);
    checkOutput("hold_err", o_err, 0);
    applyStimulus(32, 1, 1'b1, -1);

    startRun(12, 2);
    idleCheck(5);
    checkOutput("cfg_err_point12", o_err, 1);
    startRun(16, 0);
    idleCheck(5);
    checkOutput("cfg_err_burst0", o_err, 1);
    startRun(2, 1);
    idleCheck(5);
    checkOutput("cfg_err_point2", o_err, 1);

    // Abort the run while sample 5 of frame 0 is on the input.
    startRun(16, 2);
    waited = 0;
    while (in_acc != 5 && waited < 200) begin
      driveCycle(1'b0, -1);
      waited++;
    end
    checkOutput("reach_sample5", in_acc, 5);
    reset         = 1'b1;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_s_ready", s_axis_tready, 0);
    checkOutput("rst_c_in_valid", c_in_tvalid, 0);
    checkOutput("rst_c_out_ready", c_out_tready, 0);
    checkOutput("rst_m_valid", m_axis_tvalid, 0);
    checkOutput("rst_m_last", m_axis_tlast, 0);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_done", o_done, 0);
    checkOutput("rst_err", o_err, 0);
    #1;
    reset = 1'b0;
    core_flush = 1'b1;
    done_pend  = 1'b0;
    idleCheck(3);
    core_flush = 1'b0;
    checkOutput("rst_no_done", done_cnt, 0);
    applyStimulus(16, 2, 1'b1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
